// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and limits for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT} arb_state_e;
  typedef enum logic {OWN_CORE, OWN_LOADER} arb_owner_e;
  localparam int MAX_LATENCY = 4;
  localparam int LAT_W = $clog2(MAX_LATENCY);
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core, loader and memory port signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req, c_we, c_gnt, c_rvalid;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic              l_req, l_we, l_gnt, l_rvalid;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata, l_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              core_stall;
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output c_gnt, c_rvalid, c_rdata, l_gnt, l_rvalid, l_rdata,
    output mem_addr, mem_we, mem_wdata, core_stall
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  c_gnt, c_rvalid, c_rdata, l_gnt, l_rvalid, l_rdata,
    input  mem_addr, mem_we, mem_wdata, core_stall
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker, bit 0 core, bit 1 loader
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between the core and a loader master
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_LATENCY) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LATENCY must be 1..%0d", MAX_LATENCY);
  end
  arb_state_e        state, state_n;
  arb_owner_e        owner, last_owner;
  logic [LAT_W-1:0]  cnt, cnt_n;
  logic [1:0]        pick;
  logic              we_q, done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  rr_pick2 u_pick (.req({bus.l_req, bus.c_req}), .last(last_owner), .gnt(pick));
  assign done = state == RWAIT && cnt == '0;
  // next state and latency counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE:   state_n = |pick ? ACCESS : IDLE;
      ACCESS: begin
        state_n = we_q ? IDLE : RWAIT;
        cnt_n   = LAT_W'(MEM_LATENCY - 1);
      end
      RWAIT:  begin
        state_n = done ? IDLE : RWAIT;
        cnt_n   = done ? '0 : cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // capture the winning request when leaving IDLE
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner      <= OWN_CORE;
      last_owner <= OWN_LOADER;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (state == IDLE && |pick) begin
      owner      <= pick[1] ? OWN_LOADER : OWN_CORE;
      last_owner <= pick[1] ? OWN_LOADER : OWN_CORE;
      we_q       <= pick[1] ? bus.l_we : bus.c_we;
      addr_q     <= pick[1] ? bus.l_addr : bus.c_addr;
      wdata_q    <= pick[1] ? bus.l_wdata : bus.c_wdata;
    end
  // read return: capture data and pulse rvalid to the owner
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.c_rvalid <= 1'b0;
      bus.l_rvalid <= 1'b0;
      bus.c_rdata  <= '0;
      bus.l_rdata  <= '0;
    end else begin
      bus.c_rvalid <= done && owner == OWN_CORE;
      bus.l_rvalid <= done && owner == OWN_LOADER;
      if (done && owner == OWN_CORE) bus.c_rdata <= bus.mem_rdata;
      if (done && owner == OWN_LOADER) bus.l_rdata <= bus.mem_rdata;
    end
  assign bus.c_gnt      = state == ACCESS && owner == OWN_CORE;
  assign bus.l_gnt      = state == ACCESS && owner == OWN_LOADER;
  assign bus.mem_we     = state == ACCESS && we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.core_stall = reset & bus.c_req & ~((bus.c_gnt & bus.c_we) | bus.c_rvalid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the memory port arbiter at latency 1 and 3
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passes = 0;
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic seen;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifb ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_a (.clk(clk), .reset(rst_n), .bus(ifa));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut_b (.clk(clk), .reset(rst_n), .bus(ifb));
  always #5 clk = ~clk;
  // synchronous memory models, preloaded while reset is low
  always @(posedge clk) begin
    if (!rst_n) mem1[16] <= 32'hDEADBEEF;
    else if (ifa.mem_we) mem1[ifa.mem_addr[7:0]] <= ifa.mem_wdata;
    ifa.mem_rdata <= mem1[ifa.mem_addr[7:0]];
  end
  always @(posedge clk) begin
    if (!rst_n) mem3[16] <= 32'hCAFEF00D;
    else if (ifb.mem_we) mem3[ifb.mem_addr[7:0]] <= ifb.mem_wdata;
    ifb.mem_rdata <= mem3[ifb.mem_addr[7:0]];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [1:0] gexp [1:8];
    gexp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    {ifa.c_req, ifa.c_we, ifa.c_addr, ifa.c_wdata} = '0;
    {ifa.l_req, ifa.l_we, ifa.l_addr, ifa.l_wdata} = '0;
    {ifb.c_req, ifb.c_we, ifb.c_addr, ifb.c_wdata} = '0;
    {ifb.l_req, ifb.l_we, ifb.l_addr, ifb.l_wdata} = '0;
    ifa.c_req = 1'b1;
    repeat (3) tick;
    check("rst_c_gnt", 32'(ifa.c_gnt), 0);
    check("rst_l_gnt", 32'(ifa.l_gnt), 0);
    check("rst_c_rvalid", 32'(ifa.c_rvalid), 0);
    check("rst_mem_we", 32'(ifa.mem_we), 0);
    check("rst_mem_addr", ifa.mem_addr, 0);
    check("rst_c_rdata", ifa.c_rdata, 0);
    check("rst_stall", 32'(ifa.core_stall), 0);
    ifa.c_req = 1'b0;
    rst_n = 1'b1;
    tick;
    ifa.c_req = 1'b1; ifa.c_addr = 32'h10;
    #1 check("rd_t0_stall", 32'(ifa.core_stall), 1);
    tick;
    check("rd_t1_gnt", 32'(ifa.c_gnt), 1);
    check("rd_t1_addr", ifa.mem_addr, 32'h10);
    check("rd_t1_we", 32'(ifa.mem_we), 0);
    tick;
    check("rd_t2_gnt", 32'(ifa.c_gnt), 0);
    check("rd_t2_rvalid", 32'(ifa.c_rvalid), 0);
    check("rd_t2_stall", 32'(ifa.core_stall), 1);
    tick;
    check("rd_t3_rvalid", 32'(ifa.c_rvalid), 1);
    check("rd_t3_rdata", ifa.c_rdata, 32'hDEADBEEF);
    check("rd_t3_stall", 32'(ifa.core_stall), 0);
    ifa.c_req = 1'b0;
    tick;
    check("rd_t4_rvalid", 32'(ifa.c_rvalid), 0);
    check("rd_t4_rdata_hold", ifa.c_rdata, 32'hDEADBEEF);
    ifa.l_req = 1'b1; ifa.l_we = 1'b1; ifa.l_addr = 32'h20; ifa.l_wdata = 32'h12345678;
    tick;
    check("wr_t1_l_gnt", 32'(ifa.l_gnt), 1);
    check("wr_t1_mem_we", 32'(ifa.mem_we), 1);
    check("wr_t1_addr", ifa.mem_addr, 32'h20);
    check("wr_t1_wdata", ifa.mem_wdata, 32'h12345678);
    check("wr_t1_c_gnt", 32'(ifa.c_gnt), 0);
    ifa.l_req = 1'b0;
    tick;
    check("wr_t2_mem_we", 32'(ifa.mem_we), 0);
    check("wr_t2_l_gnt", 32'(ifa.l_gnt), 0);
    ifa.c_req = 1'b1; ifa.c_addr = 32'h20;
    repeat (3) tick;
    check("rdback_rvalid", 32'(ifa.c_rvalid), 1);
    check("rdback_rdata", ifa.c_rdata, 32'h12345678);
    ifa.c_req = 1'b0;
    tick;
    ifb.c_req = 1'b1; ifb.c_addr = 32'h10;
    for (int i = 1; i <= 5; i++) begin
      tick;
      check($sformatf("lat3_gnt_%0d", i), 32'(ifb.c_gnt), 32'(i == 1));
      check($sformatf("lat3_rvalid_%0d", i), 32'(ifb.c_rvalid), 32'(i == 5));
      check($sformatf("lat3_stall_%0d", i), 32'(ifb.core_stall), 32'(i != 5));
    end
    check("lat3_rdata", ifb.c_rdata, 32'hCAFEF00D);
    ifb.c_req = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    ifa.c_req = 1'b1; ifa.c_we = 1'b1; ifa.c_addr = 32'h30; ifa.c_wdata = 32'h1;
    ifa.l_req = 1'b1; ifa.l_we = 1'b1; ifa.l_addr = 32'h40; ifa.l_wdata = 32'h2;
    for (int i = 1; i <= 8; i++) begin
      tick;
      check($sformatf("rr_gnt_%0d", i), 32'({ifa.l_gnt, ifa.c_gnt}), 32'(gexp[i]));
    end
    ifa.c_req = 1'b0; ifa.l_req = 1'b0; ifa.c_we = 1'b0; ifa.l_we = 1'b0;
    repeat (2) tick;
    ifa.c_req = 1'b1; ifa.c_addr = 32'h10;
    tick;
    check("b2b_gnt1", 32'(ifa.c_gnt), 1);
    ifa.c_addr = 32'h20;
    repeat (2) tick;
    check("b2b_rvalid1", 32'(ifa.c_rvalid), 1);
    check("b2b_rdata1", ifa.c_rdata, 32'hDEADBEEF);
    tick;
    check("b2b_gnt2", 32'(ifa.c_gnt), 1);
    check("b2b_addr2", ifa.mem_addr, 32'h20);
    repeat (2) tick;
    check("b2b_rvalid2", 32'(ifa.c_rvalid), 1);
    check("b2b_rdata2", ifa.c_rdata, 32'h12345678);
    ifa.c_req = 1'b0;
    tick;
    ifb.c_req = 1'b1; ifb.c_addr = 32'h10;
    tick;
    check("abort_gnt", 32'(ifb.c_gnt), 1);
    tick;
    #1 rst_n = 1'b0;
    #1;
    check("abort_rvalid", 32'(ifb.c_rvalid), 0);
    check("abort_rdata", ifb.c_rdata, 0);
    check("abort_mem_addr", ifb.mem_addr, 0);
    check("abort_stall", 32'(ifb.core_stall), 0);
    tick;
    ifb.c_req = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick;
      seen = seen | ifb.c_rvalid | ifb.c_gnt;
    end
    check("abort_no_rvalid", 32'(seen), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
